// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader memory.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = LEN_BYTES * BYTE_W;

endpackage

// File: rtl/instr_loader_mem_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes; the word is
// presented combinationally alongside the byte that completes it.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_data,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_valid_c
);

  localparam int unsigned BUF_W = WORD_W - BYTE_W;
  localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]       r_idx;
  logic [BUF_W-1:0] r_buf;

  // Earlier bytes shift down so the oldest ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_idx <= 2'd0;
      r_buf <= '0;
    end else if (i_valid) begin
      r_buf <= {i_data, r_buf[BUF_W-1:BYTE_W]};
      r_idx <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
    end
  end

  assign o_word_c       = {i_data, r_buf};
  assign o_word_valid_c = i_valid & (r_idx == LAST_IDX);

endmodule

// File: rtl/instr_loader_mem.sv
// Writable instruction memory: loads a length-prefixed byte stream, holds the
// core in reset until a valid image is in place, and serves a combinational fetch port.
module instr_loader_mem
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH_WORDS   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [BYTE_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] A,
  output logic [WORD_W-1:0]        RD,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [CNT_W-1:0]         words_loaded
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_in_ready;
  logic             r_done;
  logic             r_error;
  logic             r_cpu_hold;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_words;
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  logic              w_acc;
  logic              w_start_take;
  logic              w_in_data_st;
  logic              w_word_valid_c;
  logic              w_word_wr;
  logic [WORD_W-1:0] w_word_c;
  logic [CNT_W-1:0]  w_len_full;
  logic [CNT_W-1:0]  w_words_inc;
  logic              w_unused_addr;

  assign w_acc        = in_valid & r_in_ready;
  assign w_start_take = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_in_data_st = w_acc & (r_state == S_DATA);
  assign w_word_wr    = w_word_valid_c & (r_state == S_DATA);
  assign w_len_full   = {in_data, r_len[BYTE_W-1:0]};
  assign w_words_inc  = r_words + CNT_W'(1);

  byte_packer u_packer (
    .clk            (clk),
    .i_clear        (rst | w_start_take),
    .i_valid        (w_in_data_st),
    .i_data         (in_data),
    .o_word_c       (w_word_c),
    .o_word_valid_c (w_word_valid_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_take) w_state_nxt = S_LEN_LO;
      S_LEN_LO: if (w_acc) w_state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (w_acc) begin
          if (w_len_full == '0)
            w_state_nxt = S_DONE;
          else if (17'(w_len_full) > 17'(DEPTH_WORDS))
            w_state_nxt = S_ERR;
          else
            w_state_nxt = S_DATA;
        end
      end
      S_DATA:   if (w_word_wr && (w_words_inc == r_len)) w_state_nxt = S_DONE;
      S_DONE:   if (w_start_take) w_state_nxt = S_LEN_LO;
      S_ERR:    if (w_start_take) w_state_nxt = S_LEN_LO;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt == S_LEN_LO) | (w_state_nxt == S_LEN_HI) |
                    (w_state_nxt == S_DATA);
      r_done     <= (w_state_nxt == S_DONE);
      r_error    <= (w_state_nxt == S_ERR);
      r_cpu_hold <= (w_state_nxt != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= '0;
      r_words <= '0;
    end else begin
      if (w_start_take)   r_words <= '0;
      else if (w_word_wr) r_words <= w_words_inc;
      if (w_acc && (r_state == S_LEN_LO)) r_len[BYTE_W-1:0]     <= in_data;
      if (w_acc && (r_state == S_LEN_HI)) r_len[CNT_W-1:BYTE_W] <= in_data;
    end
  end

  // Memory is deliberately outside reset so a reset never destroys an image.
  always_ff @(posedge clk) begin
    if (w_word_wr) r_mem[r_words[IDX_W-1:0]] <= w_word_c;
  end

  assign RD = r_mem[A[IDX_W+1:2]];

  assign w_unused_addr = ^{A[1:0], A[ADDRESS_WIDTH-1:IDX_W+2]};

  assign in_ready     = r_in_ready;
  assign done         = r_done;
  assign error        = r_error;
  assign cpu_hold     = r_cpu_hold;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_instr_loader_mem.sv
// Self-checking bench for instr_loader_mem: directed vectors plus random loads
// compared against an array model of the loaded image.
module tb_instr_loader_mem;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] RD;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_tests;
  int n_fail;

  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  logic [31:0] wbuf        [DEPTH];

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
  } rd_vec_t;

  rd_vec_t tbl [6];

  instr_loader_mem #(.ADDRESS_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .A            (A),
    .RD           (RD),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit h,
                              input bit r, input int w);
    check({tag, "_done"},     32'(done),         32'(d));
    check({tag, "_error"},    32'(error),        32'(e));
    check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'(h));
    check({tag, "_in_ready"}, 32'(in_ready),     32'(r));
    check({tag, "_words"},    32'(words_loaded), 32'(w));
  endtask

  // gaps: 0 none, 1 one idle junk cycle before each byte, 2 random idle cycles
  task automatic send_byte(input logic [7:0] b, input int gaps);
    int n_idle;
    n_idle = (gaps == 1) ? 1 : (gaps == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < n_idle; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = (gaps == 2) && ($urandom_range(0, 5) == 0);
      step();
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    check("in_ready_for_byte", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_load(input int n, input int gaps, input bit do_start);
    logic [7:0]  q [$];
    logic [15:0] len;
    len = 16'(n);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      check_status("after_start", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    end
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    if (n <= int'(DEPTH)) begin
      for (int i = 0; i < n; i++)
        for (int b = 0; b < 4; b++)
          q.push_back(wbuf[i][8*b +: 8]);
    end
    for (int k = 0; k < q.size(); k++) begin
      if (k == q.size() - 1) check("done_before_last", 32'(done), 32'd0);
      send_byte(q[k], gaps);
    end
    if (n <= int'(DEPTH)) begin
      check_status("after_load", 1'b1, 1'b0, 1'b0, 1'b0, n);
      for (int i = 0; i < n; i++) begin
        model_mem[i]   = wbuf[i];
        model_known[i] = 1'b1;
      end
    end else begin
      check_status("after_oversize", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    end
  endtask

  task automatic check_mem_all();
    logic [31:0] a;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (model_known[i]) begin
        a      = $urandom;
        a[9:2] = 8'(i);
        A      = a;
        #1;
        check("mem_read", RD, model_mem[i]);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    A        = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) model_known[i] = 1'b0;

    // 1: reset
    step();
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    rst = 1'b0;
    step();
    check_status("idle", 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // 2: nominal load and read-port decode
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h00500013;
    do_load(2, 0, 1'b1);
    tbl[0] = '{32'h0000_0000, 32'hDEADBEEF};
    tbl[1] = '{32'h0000_0003, 32'hDEADBEEF};
    tbl[2] = '{32'h0000_0004, 32'h00500013};
    tbl[3] = '{32'h0000_0007, 32'h00500013};
    tbl[4] = '{32'h0000_0404, 32'h00500013};
    tbl[5] = '{32'hFFFF_FC00, 32'hDEADBEEF};
    for (int i = 0; i < 6; i++) begin
      A = tbl[i].a;
      #1;
      check("rd_table", RD, tbl[i].rd);
    end

    // 3: same stream with an idle junk cycle before every byte
    do_load(2, 1, 1'b1);
    check_mem_all();

    // 4: zero length
    do_load(0, 0, 1'b1);
    check_mem_all();

    // 5: oversize rejected, trailing bytes ignored, then recovery
    do_load(257, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    check_status("err_after_junk", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_mem_all();
    wbuf[0] = 32'h0BADF00D;
    do_load(1, 0, 1'b1);
    check_mem_all();

    // 6: reset mid-load keeps memory, packer is cleared
    wbuf[0] = 32'h11111111;
    do_load(1, 0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_status("mid_reset", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    A = 32'h0;
    #1;
    check("mid_reset_mem0", RD, 32'h11111111);
    // start with a simultaneous byte in IDLE: byte must be dropped
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check_status("start_with_byte", 1'b0, 1'b0, 1'b1, 1'b1, 0);
    wbuf[0] = 32'hCAFEF00D;
    do_load(1, 0, 1'b0);
    check_mem_all();

    // Full depth boundary
    for (int i = 0; i < int'(DEPTH); i++) wbuf[i] = $urandom;
    do_load(int'(DEPTH), 0, 1'b1);
    check_mem_all();

    // Random loads with random gaps and ignored start pulses
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      do_load(n, 2, 1'b1);
      check_mem_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
